// File: rtl/bin_frame_writer.sv
// bin_frame_writer
//   Producer side of the binary frame buffer. Thresholds a raster-order 8-bit
//   luma stream to 1 bit per pixel and writes it at address row*HSIZE+col.
//   Once the last pixel is stored, the frame is handed to the reader with a
//   frame_available pulse. If the reader is still busy, the handover waits in
//   PENDING until the reader is free.
//
// Ports
//   clock, reset     system clock, synchronous active-high reset
//   frame_start      one-cycle pulse on the first pixel of a frame
//   pixel_valid      pixel_in is valid this cycle
//   pixel_in[7:0]    luma sample
//   threshold[7:0]   binarization threshold, latched at frame_start
//   reader_busy      reader still consuming the previous frame
//   wr_en            frame-buffer write strobe (one cycle after the pixel)
//   wr_addr          frame-buffer write address
//   wr_data          binarized pixel (pixel_in >= latched threshold)
//   frame_available  one-cycle pulse: frame complete and handed over
//   frame_error      one-cycle pulse: frame aborted by an early frame_start
//   frames_dropped   saturating count of frame_starts ignored in PENDING
//   busy             high in WRITE or PENDING
module bin_frame_writer #(
  parameter int HSIZE  = 320,
  parameter int VSIZE  = 240,
  parameter int ADDR_W = 18
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              pixel_valid,
  input  logic [7:0]        pixel_in,
  input  logic [7:0]        threshold,
  input  logic              reader_busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_data,
  output logic              frame_available,
  output logic              frame_error,
  output logic [7:0]        frames_dropped,
  output logic              busy
);

  localparam int              TOTAL = HSIZE * VSIZE;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TOTAL - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    PENDING = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   count, count_next;
  logic [7:0]          thr, thr_next;
  logic [ADDR_W-1:0]   addr_eff;
  logic [7:0]          thr_eff;
  logic                accepting;
  logic                wr_en_next, wr_data_next;
  logic [ADDR_W-1:0]   wr_addr_next;
  logic                avail_next, error_next;
  logic [7:0]          dropped_next;

  // Next-state and next-output logic. A frame_start takes effect in the same
  // cycle, so the pixel arriving with it uses address 0 and the new threshold.
  always_comb begin
    state_next   = state;
    count_next   = count;
    thr_next     = thr;
    addr_eff     = count;
    thr_eff      = thr;
    accepting    = 1'b0;
    wr_en_next   = 1'b0;
    wr_addr_next = {ADDR_W{1'b0}};
    wr_data_next = 1'b0;
    avail_next   = 1'b0;
    error_next   = 1'b0;
    dropped_next = frames_dropped;

    case (state)
      IDLE: begin
        if (frame_start) begin
          accepting  = 1'b1;
          addr_eff   = {ADDR_W{1'b0}};
          thr_eff    = threshold;
          thr_next   = threshold;
          count_next = {ADDR_W{1'b0}};
          state_next = WRITE;
        end else begin
          accepting = 1'b0;
        end
      end
      WRITE: begin
        accepting = 1'b1;
        if (frame_start) begin
          // Early restart: abort the current frame.
          error_next = 1'b1;
          addr_eff   = {ADDR_W{1'b0}};
          thr_eff    = threshold;
          thr_next   = threshold;
          count_next = {ADDR_W{1'b0}};
        end else begin
          error_next = 1'b0;
        end
      end
      PENDING: begin
        if (frame_start && (frames_dropped != 8'hFF)) begin
          dropped_next = frames_dropped + 8'd1;
        end else begin
          dropped_next = frames_dropped;
        end
        if (!reader_busy) begin
          avail_next = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = PENDING;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (accepting && pixel_valid) begin
      wr_en_next   = 1'b1;
      wr_addr_next = addr_eff;
      wr_data_next = (pixel_in >= thr_eff);
      if (addr_eff == LAST) begin
        // Last pixel: hand over now if the reader is free, else wait.
        count_next = {ADDR_W{1'b0}};
        if (reader_busy) begin
          state_next = PENDING;
        end else begin
          avail_next = 1'b1;
          state_next = IDLE;
        end
      end else begin
        count_next = addr_eff + ADDR_W'(1);
      end
    end else begin
      wr_en_next = 1'b0;
    end
  end

  // State, counter, latched threshold and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      count           <= {ADDR_W{1'b0}};
      thr             <= 8'd0;
      wr_en           <= 1'b0;
      wr_addr         <= {ADDR_W{1'b0}};
      wr_data         <= 1'b0;
      frame_available <= 1'b0;
      frame_error     <= 1'b0;
      frames_dropped  <= 8'd0;
    end else begin
      state           <= state_next;
      count           <= count_next;
      thr             <= thr_next;
      wr_en           <= wr_en_next;
      wr_addr         <= wr_addr_next;
      wr_data         <= wr_data_next;
      frame_available <= avail_next;
      frame_error     <= error_next;
      frames_dropped  <= dropped_next;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_bin_frame_writer.sv
module tb_bin_frame_writer;

  localparam int HSIZE  = 28;
  localparam int VSIZE  = 22;
  localparam int ADDR_W = 18;
  localparam int TOTAL  = HSIZE * VSIZE;

  logic              clock = 1'b0;
  logic              reset;
  logic              frame_start;
  logic              pixel_valid;
  logic [7:0]        pixel_in;
  logic [7:0]        threshold;
  logic              reader_busy;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_data;
  logic              frame_available;
  logic              frame_error;
  logic [7:0]        frames_dropped;
  logic              busy;

  bin_frame_writer #(.HSIZE(HSIZE), .VSIZE(VSIZE), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .frame_start(frame_start),
    .pixel_valid(pixel_valid), .pixel_in(pixel_in), .threshold(threshold),
    .reader_busy(reader_busy), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .frame_available(frame_available),
    .frame_error(frame_error), .frames_dropped(frames_dropped), .busy(busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;

  // Observed event counters, cleared per section.
  int n_wr, n_av, n_err;

  // Reference model: where are we in the frame, and is a handover owed.
  bit m_active, m_pending;
  int m_pos;
  int m_thr;
  int m_dropped;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic clear_counts();
    n_wr = 0; n_av = 0; n_err = 0;
  endtask

  // Predict the outputs following this clock edge from the current inputs,
  // advance one clock, then compare.
  task automatic step();
    bit e_en, e_data, e_av, e_err, e_busy;
    int e_addr;
    e_en = 0; e_data = 0; e_av = 0; e_err = 0; e_addr = 0;
    if (reset) begin
      m_active = 0; m_pending = 0; m_pos = 0; m_thr = 0; m_dropped = 0;
    end else if (m_pending) begin
      if (frame_start) m_dropped = (m_dropped < 255) ? m_dropped + 1 : 255;
      if (!reader_busy) begin
        e_av = 1;
        m_pending = 0;
      end
    end else begin
      if (frame_start) begin
        if (m_active) e_err = 1;
        m_active = 1;
        m_pos = 0;
        m_thr = int'(threshold);
      end
      if (m_active && pixel_valid) begin
        e_en   = 1;
        e_addr = m_pos;
        e_data = (int'(pixel_in) >= m_thr);
        if (m_pos == TOTAL - 1) begin
          m_active = 0;
          if (reader_busy) m_pending = 1;
          else e_av = 1;
        end else begin
          m_pos++;
        end
      end
    end
    e_busy = m_active || m_pending;

    @(posedge clock);
    #1;
    n_wr  += int'(wr_en);
    n_av  += int'(frame_available);
    n_err += int'(frame_error);
    check("wr_en", int'(wr_en), int'(e_en));
    if (e_en) begin
      check("wr_addr", int'(wr_addr), e_addr);
      check("wr_data", int'(wr_data), int'(e_data));
    end
    check("frame_available", int'(frame_available), int'(e_av));
    check("frame_error", int'(frame_error), int'(e_err));
    check("frames_dropped", int'(frames_dropped), m_dropped);
    check("busy", int'(busy), int'(e_busy));
    check("pulse_exclusive", int'(frame_available && frame_error), 0);
  endtask

  task automatic idle(input int n);
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  // Send n pixels; first one optionally carries frame_start. gap inserts an
  // idle cycle after each pixel; ramp makes the value address mod 256.
  task automatic pixels(input int n, input bit gap, input bit ramp, input bit fs_first);
    for (int k = 0; k < n; k++) begin
      frame_start = fs_first && (k == 0);
      pixel_valid = 1'b1;
      pixel_in    = ramp ? 8'(k % 256) : 8'($urandom_range(0, 255));
      step();
      if (gap) begin
        frame_start = 1'b0;
        pixel_valid = 1'b0;
        pixel_in    = 8'($urandom_range(0, 255));
        step();
      end
    end
    frame_start = 1'b0;
    pixel_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; pixel_valid = 1'b0;
    pixel_in = 8'd0; threshold = 8'd0; reader_busy = 1'b0;

    // Reset and idle behaviour
    clear_counts();
    for (int k = 0; k < 10; k++) step();
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_wr_data", int'(wr_data), 0);
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      pixel_valid = 1'($urandom_range(0, 1));
      pixel_in    = 8'($urandom_range(0, 255));
      threshold   = 8'($urandom_range(0, 255));
      step();
    end
    pixel_valid = 1'b0;
    check("idle_no_writes", n_wr, 0);

    // Ramp frame with threshold 128, then stray pixels after completion
    clear_counts();
    threshold = 8'd128;
    pixels(TOTAL, 1'b0, 1'b1, 1'b1);
    pixels(5, 1'b0, 1'b0, 1'b0);
    idle(3);
    check("ramp_writes", n_wr, TOTAL);
    check("ramp_avail", n_av, 1);

    // Gapped stream
    clear_counts();
    threshold = 8'($urandom_range(0, 255));
    pixels(TOTAL, 1'b1, 1'b0, 1'b1);
    idle(3);
    check("gap_writes", n_wr, TOTAL);
    check("gap_avail", n_av, 1);

    // Handshake: reader busy through end of frame
    clear_counts();
    reader_busy = 1'b1;
    threshold = 8'($urandom_range(0, 255));
    pixels(TOTAL, 1'b0, 1'b0, 1'b1);
    idle(5);
    check("pend_busy", int'(busy), 1);
    check("pend_no_avail", n_av, 0);
    frame_start = 1'b1; pixel_valid = 1'b1; step();
    idle(3);
    check("pend_dropped", int'(frames_dropped), 1);
    reader_busy = 1'b0;
    idle(3);
    check("pend_avail", n_av, 1);
    check("pend_idle", int'(busy), 0);
    check("pend_writes", n_wr, TOTAL);

    // Abort after 300 pixels, then a full frame
    clear_counts();
    threshold = 8'($urandom_range(0, 255));
    pixels(300, 1'b0, 1'b0, 1'b1);
    threshold = 8'($urandom_range(0, 255));
    pixels(TOTAL, 1'b0, 1'b0, 1'b1);
    idle(3);
    check("abort_err", n_err, 1);
    check("abort_avail", n_av, 1);

    // Reset at pixel 400, then a full frame
    clear_counts();
    pixels(400, 1'b0, 1'b0, 1'b1);
    reset = 1'b1; step(); step(); reset = 1'b0;
    threshold = 8'($urandom_range(0, 255));
    pixels(TOTAL, 1'b0, 1'b0, 1'b1);
    idle(3);
    check("rst_mid_avail", n_av, 1);
    check("rst_mid_dropped", int'(frames_dropped), 0);
    check("rst_mid_err", n_err, 0);

    // frames_dropped saturation
    clear_counts();
    reader_busy = 1'b1;
    pixels(TOTAL, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 260; k++) begin
      frame_start = 1'b1; step();
      frame_start = 1'b0; step();
    end
    check("sat_dropped", int'(frames_dropped), 255);
    reader_busy = 1'b0;
    idle(2);
    check("sat_avail", n_av, 1);

    // Random mix
    for (int k = 0; k < 4000; k++) begin
      frame_start = ($urandom_range(0, 799) == 0);
      pixel_valid = 1'($urandom_range(0, 1));
      pixel_in    = 8'($urandom_range(0, 255));
      threshold   = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 49) == 0) reader_busy = ~reader_busy;
      step();
    end
    idle(2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/bin_frame_writer.md
Name: bin_frame_writer

Overview:
- Producer side of the binary frame buffer that image_process reads through bin_index/pixel_val.
- Accepts a raster-order 8-bit luma stream from the camera front end and thresholds each pixel to 1 bit.
- Writes each bit to the frame-buffer write port at address row*HSIZE+col.
- Pulses frame_available when a complete frame is stored and the reader is free to take it.

Parameters:
- HSIZE, 320, pixels per line.
- VSIZE, 240, lines per frame; HSIZE*VSIZE must be ≤ 2^18.
- ADDR_W, 18, address width, matches bin_index.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse marking the first pixel of a frame
- pixel_valid  in  1  pixel_in is valid this cycle
- pixel_in  in  8  luma sample
- threshold  in  8  binarization threshold, sampled at frame_start
- reader_busy  in  1  high while image_process is consuming the previous frame
- wr_en  out  1  frame-buffer write strobe
- wr_addr  out  ADDR_W  frame-buffer write address
- wr_data  out  1  binarized pixel
- frame_available  out  1  one-cycle pulse: frame complete and handed over
- frame_error  out  1  one-cycle pulse: frame aborted by early frame_start
- frames_dropped  out  8  saturating count of frames ignored while pending
- busy  out  1  high in WRITE or PENDING

Behaviour:
- Reset: all outputs 0, state IDLE, pixel counter 0, latched threshold 0.
- Reset mid-frame: frame discarded and no pulse issued; next frame_start starts at address 0.
- States: IDLE, WRITE, PENDING.
- IDLE:
  - frame_start → WRITE; latch threshold; counter = 0.
  - pixel_valid without frame_start is ignored.
- WRITE, per accepted pixel (pixel_valid=1):
  - Next cycle: wr_en=1, wr_addr=counter, wr_data=(pixel_in ≥ latched threshold).
  - Counter then increments. Fixed latency of 1 cycle, no back-pressure.
  - Pixel with pixel_valid=1 in the same cycle as frame_start is address 0.
- Frame complete: the pixel written at address HSIZE*VSIZE-1 completes the frame.
  - If reader_busy=0 in that pixel's accept cycle: frame_available pulses in the cycle of its wr_en; → IDLE.
  - Else → PENDING.
- PENDING:
  - Writes blocked; pixel_valid ignored.
  - First cycle with reader_busy=0 → frame_available pulse that cycle (combinationally-registered: asserted the cycle after reader_busy is sampled low); → IDLE.
  - frame_start in PENDING → frames_dropped += 1, saturating at 255; frame ignored.
- frame_start while in WRITE (before the last pixel):
  - frame_error pulses next cycle; no frame_available.
  - Restart at address 0 with a newly latched threshold.
  - A pixel in that cycle is address 0 of the new frame.
- Pixels beyond HSIZE*VSIZE (after completion) are ignored until the next frame_start.
- Counter never wraps; wr_addr never exceeds HSIZE*VSIZE-1.
- busy = (state != IDLE).
- frame_available and frame_error are never both high in the same cycle.

Test Plan (HSIZE=28, VSIZE=22, 616 pixels):
- Reset held for 10 cycles, then idle → all outputs 0; pixels sent with no frame_start produce no wr_en.
- Threshold: threshold=128, frame_start, 616 consecutive pixels with value = address mod 256, reader_busy=0:
  - 616 wr_en, addresses 0..615 in order.
  - wr_data = 1 exactly where (addr mod 256) ≥ 128.
  - frame_available is a single pulse on the wr_en of address 615.
- Gapped stream: pixel_valid toggling 1/0 → still 616 writes, each 1 cycle after its pixel; pulse after the last one.
- Handshake: reader_busy=1 through the end of the frame → PENDING, no pulse.
  - frame_start during PENDING → frames_dropped=1.
  - Release reader_busy → exactly one frame_available pulse, then busy=0.
- Abort: frame_start after 300 pixels → frame_error pulse, next write at address 0, full frame then completes normally.
- Reset asserted at pixel 400, then a new full frame → writes restart at 0, exactly one frame_available, frames_dropped=0.
